// File: rtl/gear32_20_seq.sv
// gear32_20_seq: phase sequencer and frame-lock
// controller for the 32->20 gearbox.
module gear32_20_seq #(
  parameter int LOCK_ACQ  = 2,
  parameter int LOCK_LOSS = 4,
  parameter int Q_LAT     = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sof,
  input  logic slip,
  output logic A_or_C,
  output logic A_or_B,
  output logic q_valid,
  output logic q_first,
  output logic locked,
  output logic sof_err
);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } st_e;

  localparam logic [2:0] ACQ  = 3'(LOCK_ACQ);
  localparam logic [2:0] LOSS = 3'(LOCK_LOSS);

  // ph bit 0 = A ... bit 4 = E
  logic [4:0] ph_q, ph_d, ph_rot;
  st_e        st_q, st_d;
  logic [2:0] good_q, good_d;
  logic [2:0] miss_q, miss_d;
  logic       err_q, err_d;
  logic       fv_q, fv_d;
  logic       ph_a, v, f;
  logic [Q_LAT-1:0] v_sr_q, f_sr_q;

  function automatic logic [2:0] sat_inc(
    input logic [2:0] c
  );
    return (c == 3'd7) ? c : c + 3'd1;
  endfunction

  assign ph_a   = ph_q[0];
  assign ph_rot = {ph_q[3:0], ph_q[4]};

  // State, counters and frame flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ph_q   <= 5'b00001;
      st_q   <= HUNT;
      good_q <= '0;
      miss_q <= '0;
      err_q  <= 1'b0;
      fv_q   <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      st_q   <= st_d;
      good_q <= good_d;
      miss_q <= miss_d;
      err_q  <= err_d;
      fv_q   <= fv_d;
    end
  end

  // Qualifier delay line matching gearbox latency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_sr_q <= '0;
      f_sr_q <= '0;
    end else begin
      v_sr_q[0] <= v;
      f_sr_q[0] <= f;
      for (int i = 1; i < Q_LAT; i++) begin
        v_sr_q[i] <= v_sr_q[i-1];
        f_sr_q[i] <= f_sr_q[i-1];
      end
    end
  end

  // Next phase, lock state and counters
  always_comb begin
    ph_d   = ph_rot;
    st_d   = st_q;
    good_d = good_q;
    miss_d = miss_q;
    err_d  = 1'b0;
    unique case (st_q)
      HUNT: begin
        if (sof) begin
          ph_d   = 5'b00010;
          good_d = ph_a ? sat_inc(good_q) : 3'd1;
        end else begin
          if (slip) ph_d = ph_q;
          if (ph_a) good_d = '0;
        end
        if (good_d >= ACQ) begin
          st_d   = LOCK;
          miss_d = '0;
        end
      end
      LOCK: begin
        if (ph_a) begin
          miss_d = sof ? '0 : sat_inc(miss_q);
        end else if (sof) begin
          miss_d = sat_inc(miss_q);
          err_d  = 1'b1;
        end
        if (miss_d >= LOSS) begin
          st_d   = HUNT;
          good_d = '0;
        end
      end
    endcase
  end

  // Output decode and per-cycle qualifiers
  always_comb begin
    locked  = (st_q == LOCK);
    A_or_C  = ph_q[0] | ph_q[2];
    A_or_B  = ph_q[0] | ph_q[1];
    sof_err = err_q;
    fv_d    = locked & (ph_a | fv_q);
    v       = fv_d;
    f       = ph_a & locked;
    q_valid = v_sr_q[Q_LAT-1];
    q_first = f_sr_q[Q_LAT-1];
  end

endmodule

// File: tb/tb_gear32_20_seq.sv
// tb_gear32_20_seq: scoreboard bench with a
// phase-counting reference model.
module tb_gear32_20_seq;

  localparam int LOCK_ACQ  = 2;
  localparam int LOCK_LOSS = 4;
  localparam int Q_LAT     = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sof   = 1'b0;
  logic slip  = 1'b0;
  logic A_or_C, A_or_B, q_valid, q_first;
  logic locked, sof_err;

  gear32_20_seq #(
    .LOCK_ACQ (LOCK_ACQ),
    .LOCK_LOSS(LOCK_LOSS),
    .Q_LAT    (Q_LAT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sof    (sof),
    .slip   (slip),
    .A_or_C (A_or_C),
    .A_or_B (A_or_B),
    .q_valid(q_valid),
    .q_first(q_first),
    .locked (locked),
    .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  typedef logic [5:0] exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  int m_ph   = 0;
  int m_good = 0;
  int m_miss = 0;
  bit m_lk   = 0;
  bit m_err  = 0;
  bit m_fv   = 0;
  bit hv[$];
  bit hf[$];

  function automatic int sat7(input int x);
    return (x > 7) ? 7 : x;
  endfunction

  task automatic step(input bit r, input bit s,
                      input bit sl);
    bit a, nfv, f;
    @(negedge clk);
    rst_n = r;
    sof   = s;
    slip  = sl;
    if (!r) begin
      m_ph = 0; m_lk = 0; m_good = 0;
      m_miss = 0; m_err = 0; m_fv = 0;
      hv.delete();
      hf.delete();
      repeat (Q_LAT) begin
        hv.push_back(1'b0);
        hf.push_back(1'b0);
      end
    end else begin
      a   = (m_ph == 0);
      nfv = m_lk && (a || m_fv);
      f   = a && m_lk;
      m_err = 0;
      if (!m_lk) begin
        if (s) begin
          m_good = a ? sat7(m_good + 1) : 1;
          m_ph   = 1;
        end else begin
          if (a) m_good = 0;
          if (!sl) m_ph = (m_ph + 1) % 5;
        end
        if (m_good >= LOCK_ACQ) begin
          m_lk = 1;
          m_miss = 0;
        end
      end else begin
        m_ph = (m_ph + 1) % 5;
        if (a) m_miss = s ? 0 : sat7(m_miss + 1);
        else if (s) begin
          m_miss = sat7(m_miss + 1);
          m_err = 1;
        end
        if (m_miss >= LOCK_LOSS) begin
          m_lk = 0;
          m_good = 0;
        end
      end
      m_fv = nfv;
      hv.push_back(nfv);
      hf.push_back(f);
      void'(hv.pop_front());
      void'(hf.pop_front());
    end
    exp_q.push_back({(m_ph == 0 || m_ph == 2),
                     (m_ph <= 1), m_lk, m_err,
                     hv[0], hf[0]});
  endtask

  task automatic wait_ph(input int p);
    for (int i = 0; i < 5 && m_ph != p; i++)
      step(1, 0, 0);
  endtask

  task automatic run_frame(input logic [4:0] sm,
                           input logic [4:0] slm);
    logic [4:0] s_v, l_v;
    for (int i = 0; i < 5; i++) begin
      s_v = sm;
      l_v = slm;
      step(1, s_v[m_ph], l_v[m_ph]);
    end
  endtask

  // Monitor: compare DUT outputs to queued expectations
  initial begin
    exp_t e, g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        g = {A_or_C, A_or_B, locked, sof_err,
             q_valid, q_first};
        checks++;
        if (g !== e) begin
          errors++;
          $display({"FAIL outputs @%0t ",
                    "(ac ab lk err qv qf): ",
                    "got %b want %b"}, $time, g, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(0, 0, 0);
    step(0, 0, 0);
    repeat (12) step(1, 0, 0);
    // acquire from an off-phase sof at C
    wait_ph(2);
    step(1, 1, 0);
    repeat (5) run_frame(5'b00001, 5'b00000);
    // loss
    repeat (6) run_frame(5'b00000, 5'b00000);
    // reacquire
    repeat (4) run_frame(5'b00001, 5'b00000);
    // off-phase sof at D while locked
    repeat (4) run_frame(5'b01001, 5'b00000);
    repeat (2) run_frame(5'b01111, 5'b00000);
    // slip at B while locked is ignored
    repeat (2) run_frame(5'b00001, 5'b00010);
    // drop lock, then slip pulse in hunt
    repeat (6) run_frame(5'b00000, 5'b00000);
    wait_ph(1);
    step(1, 0, 1);
    repeat (3) step(1, 0, 0);
    // sof with slip at A in hunt counts as good
    wait_ph(0);
    step(1, 1, 1);
    repeat (6) run_frame(5'b00001, 5'b00000);
    // reset mid-frame while locked
    wait_ph(3);
    step(0, 0, 0);
    repeat (8) step(1, 0, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, s, sl;
      r  = ($urandom_range(0, 599) != 0);
      s  = (m_ph == 0) ? ($urandom_range(0, 9) != 0)
                       : ($urandom_range(0, 29) == 0);
      sl = ($urandom_range(0, 14) == 0);
      step(r, s, sl);
    end
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d left, want 0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/gear32_20_seq.md
# gear32_20_seq

Phase sequencer and frame-lock controller for the 32→20 gearbox (`gear32_20`).
- Tracks which of the five input words (A–E) of each 160-bit frame is on the gearbox `Din` this cycle.
- Drives the gearbox `A_or_C`/`A_or_B` controls.
- Acquires and maintains alignment from a start-of-frame marker.
- Emits valid/first qualifiers aligned with the gearbox `Q` output.
- Sits beside the gearbox: its inputs come from the same upstream as `Din`, and its qualifiers travel with `Q` downstream.

## Interface
Parameters:
- `LOCK_ACQ`, 2: consecutive aligned frames needed to enter LOCKED (1..7).
- `LOCK_LOSS`, 4: consecutive bad frames needed to drop to HUNT (1..7).
- `Q_LAT`, 3: gearbox latency in cycles, from the `Din` phase-A cycle to `Q` carrying the first output word of that frame.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: synchronous reset, active-low.
- `sof`, in, 1: high in the cycle `Din` carries word A.
- `slip`, in, 1: in HUNT, hold the phase for one cycle.
- `A_or_C`, out, 1: gearbox control, high when the phase is A or C.
- `A_or_B`, out, 1: gearbox control, high when the phase is A or B.
- `q_valid`, out, 1: `Q` holds a valid word of a locked frame.
- `q_first`, out, 1: `Q` holds the first of the 5 output words of a frame.
- `locked`, out, 1: frame lock status.
- `sof_err`, out, 1: one-cycle pulse for a `sof` seen off-phase while LOCKED.

## Operation
- **Phase register `ph`:** one-hot {A,B,C,D,E}. It names the word on `Din` this cycle and advances A→B→C→D→E→A every cycle, except as noted below. `A_or_C` and `A_or_B` decode directly from `ph` with no further logic.
- **States:** HUNT and LOCKED. `locked` = (state == LOCKED), registered.
- **HUNT:**
  - `sof`=1: the cycle is treated as A, so `ph_next` = B regardless of the current `ph`.
    - If `ph` was already A, `good_cnt`++.
    - Otherwise (realign), `good_cnt` = 1.
  - `ph`==A with `sof`=0: `good_cnt` = 0. No realign.
  - `slip`=1 with `sof`=0: `ph` holds one cycle.
  - `sof` overrides `slip`.
  - When `good_cnt` reaches `LOCK_ACQ`: go to LOCKED, `miss_cnt` = 0.
- **LOCKED:**
  - `slip` is ignored. `ph` never realigns.
  - `ph`==A with `sof`=1: `miss_cnt` = 0.
  - `ph`==A with `sof`=0: `miss_cnt`++.
  - `sof`=1 with `ph`≠A: `miss_cnt`++ and `sof_err` pulses next cycle.
  - When `miss_cnt` reaches `LOCK_LOSS`: go to HUNT, `good_cnt` = 0.
- **Counters:** 3 bits, saturating. No wrap.
- **Qualifiers:**
  - Frame flag `fv`: set at a `ph`==A cycle when `locked`=1; cleared at a `ph`==A cycle when `locked`=0, or in any cycle `locked` is 0.
  - Per cycle, `v` = `fv_next` (the value being loaded) and `f` = (`ph`==A && `locked`).
  - `q_valid` and `q_first` are `v` and `f` delayed by exactly `Q_LAT` cycles through a shift line.
  - Each locked frame therefore yields one `q_first` followed by 5 consecutive `q_valid` cycles (`q_first` coincides with the first).

## Timing
- **Reset (`rst_n`=0 at an edge):**
  - `ph` = A, so `A_or_C`=1 and `A_or_B`=1.
  - State HUNT; `locked`=0.
  - `good_cnt`, `miss_cnt` = 0; `sof_err`=0.
  - Qualifier shift line cleared, so `q_valid`=`q_first`=0 from the next cycle.
  - Applies mid-frame and while LOCKED alike.
- **First cycle after reset release:** `ph`=A. An unaligned `sof` realigns with no penalty cycle beyond the realign itself.
- **Realign penalty:** the frame straddling a realign is garbage in the gearbox. It is never qualified, because `locked` is 0 in HUNT.
- **Lock acquisition:** `locked` rises the cycle after the `sof` that completes `LOCK_ACQ`. That frame is not qualified; the first `q_first` follows the next phase-A cycle by `Q_LAT`.
- **Lock loss:** `locked` falls the cycle after the `LOCK_LOSS`-th bad frame event. `q_valid` falls `Q_LAT` cycles after that.
- **Simultaneous events:**
  - `sof` with `ph`==A counts as good even if `slip`=1.
  - `sof_err` and a `miss_cnt` increment from the same event occur together.

## Test plan
- **Free-run:** reset, `sof`=0 → (`A_or_C`,`A_or_B`) repeats (1,1),(0,1),(1,0),(0,0),(0,0) from the first post-reset cycle; `locked`=0, `q_valid`=0 throughout.
- **Acquire:** `sof` at `ph`=C (cycle t), then every 5 cycles → `ph`=B at t+1; `locked`=1 at t+6; first `q_first` at t+10+3=t+13; `q_valid` high continuously from t+13.
- **Loss:** LOCKED, then `sof` withheld → `locked`=0 the cycle after the 4th missing phase-A; `q_valid` low 3 cycles later; the next `sof` realigns.
- **Off-phase `sof`:** while LOCKED, `sof` at `ph`=D → `sof_err`=1 for one cycle, `ph` unchanged, `locked` stays 1; the next aligned `sof` clears the miss count (verify 3 further off-phase events alone do not drop lock).
- **Slip:** in HUNT, `slip` pulse at `ph`=B → `ph` sequence B,B,C; the same pulse while LOCKED → no change.
- **Reset mid-frame:** reset while LOCKED at `ph`=D with `q_valid`=1 → next cycle `ph`=A, `locked`=0, `q_valid`=`q_first`=0.
